spi_cmd_master: RTL

SPI command transmitter that drives the `Sclk`/`Mosi`/`CSel` input port of the VGA frame-buffer controller from an on-chip host such as a CPU, a DMA engine or a pattern generator. Bytes are pushed through a valid/ready interface into a small FIFO. Each byte is serialised MSB-first as one SPI mode-0 frame, with `CSel` framing every byte individually, matching the slave's command protocol. Example command sequences are 0x20 followed by a data byte, and 0x11 / 0x00 / 0x10.

---
 rtl/spi_cmd_master_if.sv | 25 ++
 rtl/spi_cmd_master.sv | 122 ++++++++++++
 2 files changed

// File: rtl/spi_cmd_master_if.sv
// Host-side byte stream and SPI pins of spi_cmd_master, bundled for port hookup.
interface spi_cmd_master_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    TxData;
  logic          TxValid;
  logic          TxReady;
  logic [LW-1:0] FifoLevel;
  logic          Busy;
  logic          Sclk;
  logic          Mosi;
  logic          CSel;

  modport master (
    output TxData, TxValid,
    input  TxReady, FifoLevel, Busy, Sclk, Mosi, CSel
  );

  modport slave (
    input  TxData, TxValid,
    output TxReady, FifoLevel, Busy, Sclk, Mosi, CSel
  );
endinterface

// File: rtl/spi_cmd_master.sv
// Byte FIFO feeding an SPI mode-0 serialiser, one CSel-framed MSB-first byte per frame.
// All pins are registered from next-state values; TxReady drops only when the FIFO is full.
module spi_cmd_master #(
  parameter int HALF_PERIOD = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             MainClkSrc,
  input  logic             Reset,
  spi_cmd_master_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_TAIL, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level, w_level_nxt;
  logic [PW-1:0] r_phase;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic          r_tx_ready, r_busy, r_sclk, r_mosi, r_csel;
  logic          w_push, w_pop, w_phase_end, w_fifo_empty;

  assign w_fifo_empty = (r_level == '0);
  assign w_phase_end  = (r_phase == PH_LAST);
  assign w_push       = bus.TxValid & r_tx_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = r_mem[r_rd_ptr];
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_SETUP;
        end
      end
      S_SETUP: if (w_phase_end) w_state_nxt = S_LOW;
      S_LOW:   if (w_phase_end) w_state_nxt = S_HIGH;
      S_HIGH: begin
        if (w_phase_end) begin
          w_shift_nxt   = {r_shift[6:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          w_state_nxt   = (r_bit_cnt == 3'd7) ? S_TAIL : S_LOW;
        end
      end
      S_TAIL: if (w_phase_end) w_state_nxt = S_GAP;
      S_GAP: begin
        // Back-to-back bytes skip IDLE so the CSel gap is a single half period.
        if (w_phase_end) begin
          if (!w_fifo_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = r_mem[r_rd_ptr];
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_SETUP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LVL_ONE;
    else if (!w_push && w_pop) w_level_nxt = r_level - LVL_ONE;
  end

  always_ff @(posedge MainClkSrc) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.TxData;
  end

  always_ff @(posedge MainClkSrc or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_csel     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= (w_state_nxt != r_state) ? '0 : r_phase + PH_ONE;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_level   <= w_level_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      // Pins follow the state being entered so they change on the same edge as the state.
      r_tx_ready <= (w_level_nxt != LVL_FULL);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_sclk     <= (w_state_nxt == S_HIGH);
      r_mosi     <= ((w_state_nxt == S_LOW) || (w_state_nxt == S_HIGH)) ? w_shift_nxt[7] : 1'b0;
      r_csel     <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
    end
  end

  assign bus.TxReady   = r_tx_ready;
  assign bus.FifoLevel = r_level;
  assign bus.Busy      = r_busy;
  assign bus.Sclk      = r_sclk;
  assign bus.Mosi      = r_mosi;
  assign bus.CSel      = r_csel;
endmodule
